// File: rtl/seg7_mux_drv.sv
// ---------------------------------------------------------------------------
// seg7_mux_drv
//
// Time-multiplexed driver for a common-anode style 7-segment display bank.
// One digit is lit per time slot. A full pass over all digits is one frame.
// The displayed value is captured once per frame, so the visible digits
// always belong to the same sample of the inputs.
//
// Features:
//   - Blanking window at the start of every slot. All anodes are off during
//     it so the previous digit's segments do not ghost onto the next one.
//   - BCD decode. Codes 10..15 show a single dash.
//   - Optional leading-zero suppression. Digit 0 is always shown.
//   - Per-digit blink. The blink period is counted in whole frames.
//
// Parameters:
//   NUM_DIGITS   number of multiplexed digits (1..8)
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   BLANK_CYC    blanked cycles at the start of each slot (< REFRESH_DIV)
//   BLINK_FRAMES frames per blink half-period (>= 1)
//
// Ports:
//   clk        system clock; all state changes on its rising edge
//   rst_n      asynchronous, active-low reset
//   en         scan enable; while low the display is dark and the scan
//              restarts from the first slot
//   digits     BCD codes; digit i is at [4i+3:4i], digit 0 is rightmost
//   dp_in      decimal point request, one bit per digit
//   blink_mask digits that should blink
//   lz_en      leading-zero suppression enable
//   seg        active-high segments, seg[6]=A ... seg[0]=G (registered)
//   dp         active-high decimal point (registered)
//   an         active-low digit anodes, at most one low (registered)
// ---------------------------------------------------------------------------
module seg7_mux_drv #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 60
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      lz_en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an
);

  // -------------------------------------------------------------------------
  // Counter widths and terminal values
  // -------------------------------------------------------------------------
  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  // -------------------------------------------------------------------------
  // Segment patterns (A..G, active high)
  // -------------------------------------------------------------------------
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'd0:    pattern = 7'b1111110;
      4'd1:    pattern = 7'b0110000;
      4'd2:    pattern = 7'b1101101;
      4'd3:    pattern = 7'b1111001;
      4'd4:    pattern = 7'b0110011;
      4'd5:    pattern = 7'b1011011;
      4'd6:    pattern = 7'b1011111;
      4'd7:    pattern = 7'b1110000;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1111011;
      default: pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [SW-1:0]           slot_cnt;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;

  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blink;
  logic                    snap_lz;

  // Next-state values
  logic [SW-1:0]           slot_nxt;
  logic [IW-1:0]           idx_nxt;
  logic [FW-1:0]           frame_nxt;
  logic                    phase_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  // Scan position decode
  logic                    slot_last;
  logic                    idx_last;
  logic                    frame_start;
  logic                    frame_end;
  logic                    in_blank;

  always_comb begin
    slot_last   = (slot_cnt == SLOT_LAST);
    idx_last    = (idx == IDX_LAST);
    frame_start = (slot_cnt == '0) && (idx == '0);
    frame_end   = slot_last && idx_last;
    in_blank    = (int'(slot_cnt) < BLANK_CYC);
  end

  // -------------------------------------------------------------------------
  // Effective display data for this cycle.
  // On the first cycle of a frame the snapshot registers are being loaded on
  // this same edge. Their new contents are therefore taken straight from the
  // inputs. This way even a zero-length blanking window shows fresh data.
  // -------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] eff_digits;
  logic [NUM_DIGITS-1:0]   eff_dp;
  logic [NUM_DIGITS-1:0]   eff_blink;
  logic                    eff_lz;
  logic                    take_snap;

  always_comb begin
    take_snap  = en && frame_start;
    eff_digits = take_snap ? digits     : snap_digits;
    eff_dp     = take_snap ? dp_in      : snap_dp;
    eff_blink  = take_snap ? blink_mask : snap_blink;
    eff_lz     = take_snap ? lz_en      : snap_lz;
  end

  // -------------------------------------------------------------------------
  // Leading-zero suppression mask.
  // Walk from the most significant digit downward. A digit is suppressed
  // while every digit from the top down to it is zero. Digit 0 never is.
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] suppress;
  logic                  zero_run;

  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run && (eff_digits[4*i +: 4] == 4'h0);
      suppress[i] = eff_lz && zero_run && (i != 0);
    end
  end

  // -------------------------------------------------------------------------
  // Select the attributes of the digit at the current scan index. The loop
  // compare keeps the selection in range for non power-of-two digit counts.
  // -------------------------------------------------------------------------
  logic [3:0] cur_code;
  logic       cur_dp;
  logic       cur_blink;
  logic       cur_sup;

  always_comb begin
    cur_code  = 4'h0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_sup   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_code  = eff_digits[4*i +: 4];
        cur_dp    = eff_dp[i];
        cur_blink = eff_blink[i];
        cur_sup   = suppress[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scan, frame and blink sequencing.
  // While disabled, everything is parked at the first slot of a frame with
  // the blink phase visible. The first enabled edge therefore starts a
  // clean frame.
  // -------------------------------------------------------------------------
  always_comb begin
    slot_nxt  = '0;
    idx_nxt   = '0;
    frame_nxt = '0;
    phase_nxt = 1'b1;
    if (en) begin
      slot_nxt  = slot_last ? '0 : slot_cnt + 1'b1;
      idx_nxt   = idx;
      frame_nxt = frame_cnt;
      phase_nxt = blink_phase;
      if (slot_last) begin
        idx_nxt = idx_last ? '0 : idx + 1'b1;
      end
      if (frame_end) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_nxt = '0;
          phase_nxt = ~blink_phase;
        end else begin
          frame_nxt = frame_cnt + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output decode for the slot being processed this cycle.
  // Segments and decimal point are forced dark whenever no anode is driven.
  // A blinking digit in its hidden phase keeps its anode scanning, but it
  // shows nothing.
  // -------------------------------------------------------------------------
  logic visible;

  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b0;
    visible = !(cur_blink && !blink_phase);
    if (en && !in_blank) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_nxt[i] = (idx != IW'(i));
      end
      if (visible) begin
        seg_nxt = cur_sup ? SEG_OFF : bcd_to_seg(cur_code);
        dp_nxt  = cur_dp;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scan counters and blink state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      slot_cnt    <= slot_nxt;
      idx         <= idx_nxt;
      frame_cnt   <= frame_nxt;
      blink_phase <= phase_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Frame snapshot. It is loaded only on the first slot of a frame.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blink  <= '0;
      snap_lz     <= 1'b0;
    end else if (take_snap) begin
      snap_digits <= digits;
      snap_dp     <= dp_in;
      snap_blink  <= blink_mask;
      snap_lz     <= lz_en;
    end
  end

  // -------------------------------------------------------------------------
  // Registered display outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b0;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_mux_drv.sv
// ---------------------------------------------------------------------------
// tb_seg7_mux_drv
//
// Self-checking bench for seg7_mux_drv with a small configuration:
// 4 digits, 4 cycles per slot, 1 blanking cycle and 2 frames per blink
// half-period. One frame is therefore 16 clock edges.
//
// Edge k of a frame (k counted from the first enabled edge) processes
// slot k%4 of digit k/4. The output after that edge is dark when k%4==0.
// Otherwise it lights digit k/4 with the expected pattern.
// ---------------------------------------------------------------------------
module tb_seg7_mux_drv;

  localparam int ND = 4;

  // Hand-written segment patterns (A..G)
  localparam logic [6:0] S0   = 7'b1111110;
  localparam logic [6:0] S1   = 7'b0110000;
  localparam logic [6:0] S2   = 7'b1101101;
  localparam logic [6:0] S3   = 7'b1111001;
  localparam logic [6:0] S4   = 7'b0110011;
  localparam logic [6:0] S5   = 7'b1011011;
  localparam logic [6:0] S6   = 7'b1011111;
  localparam logic [6:0] S7   = 7'b1110000;
  localparam logic [6:0] S8   = 7'b1111111;
  localparam logic [6:0] S9   = 7'b1111011;
  localparam logic [6:0] SD   = 7'b0000001;
  localparam logic [6:0] SOFF = 7'b0000000;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [15:0]   digits;
  logic [3:0]    dp_in;
  logic [3:0]    blink_mask;
  logic          lz_en;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;

  int tests_run;
  int tests_failed;

  // One table entry: inputs and the expected pattern/dp of each digit.
  // seg_exp holds {digit3, digit2, digit1, digit0}.
  typedef struct {
    string       name;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blink;
    logic        lz;
    logic [27:0] seg_exp;
    logic [3:0]  dp_exp;
  } vec_t;

  vec_t vecs [8];

  seg7_mux_drv #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (4),
    .BLANK_CYC    (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits     (digits),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .lz_en      (lz_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int k,
                             input logic [3:0] exp_an, input logic [6:0] exp_seg,
                             input logic exp_dp);
    tests_run++;
    if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
      tests_failed++;
      $display("[TB] FAIL %s k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               name, k, an, seg, dp, exp_an, exp_seg, exp_dp);
    end
  endtask

  // Load inputs and restart the scan: one disabled edge, then enable
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv,
                               input logic [3:0] bm, input logic lz);
    digits     = d;
    dp_in      = dpv;
    blink_mask = bm;
    lz_en      = lz;
    en         = 1'b0;
    step();
    en         = 1'b1;
  endtask

  // Clock one edge of a running scan and check it against the expected frame
  task automatic runEdge(input string name, input int k,
                         input logic [27:0] segs, input logic [3:0] dps);
    int         slot;
    int         di;
    logic [3:0] exp_an;
    step();
    slot   = k % 4;
    di     = (k / 4) % 4;
    exp_an = 4'b1111;
    if (slot == 0) begin
      checkOutput(name, k, exp_an, SOFF, 1'b0);
    end else begin
      exp_an[di] = 1'b0;
      checkOutput(name, k, exp_an, segs[7*di +: 7], dps[di]);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{name:"count_1234", digits:16'h1234, dp_in:4'b0000, blink:4'b0000, lz:1'b0,
                seg_exp:{S1, S2, S3, S4}, dp_exp:4'b0000};
    vecs[1] = '{name:"lz_0070", digits:16'h0070, dp_in:4'b0000, blink:4'b0000, lz:1'b1,
                seg_exp:{SOFF, SOFF, S7, S0}, dp_exp:4'b0000};
    vecs[2] = '{name:"lz_0000", digits:16'h0000, dp_in:4'b0000, blink:4'b0000, lz:1'b1,
                seg_exp:{SOFF, SOFF, SOFF, S0}, dp_exp:4'b0000};
    vecs[3] = '{name:"nolz_0000", digits:16'h0000, dp_in:4'b0000, blink:4'b0000, lz:1'b0,
                seg_exp:{S0, S0, S0, S0}, dp_exp:4'b0000};
    vecs[4] = '{name:"dp_5689", digits:16'h5689, dp_in:4'b1010, blink:4'b0000, lz:1'b0,
                seg_exp:{S5, S6, S8, S9}, dp_exp:4'b1010};
    vecs[5] = '{name:"invalid_ABCF", digits:16'hABCF, dp_in:4'b0000, blink:4'b0000, lz:1'b1,
                seg_exp:{SD, SD, SD, SD}, dp_exp:4'b0000};
    vecs[6] = '{name:"lz_gap_0305", digits:16'h0305, dp_in:4'b1000, blink:4'b0000, lz:1'b1,
                seg_exp:{SOFF, S3, S0, S5}, dp_exp:4'b1000};
    vecs[7] = '{name:"blink_visible", digits:16'h7890, dp_in:4'b1111, blink:4'b1111, lz:1'b1,
                seg_exp:{S7, S8, S9, S0}, dp_exp:4'b1111};

    // Asynchronous reset with no clock edge yet
    rst_n      = 1'b1;
    en         = 1'b0;
    digits     = 16'h0;
    dp_in      = 4'h0;
    blink_mask = 4'h0;
    lz_en      = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_state", 0, 4'b1111, SOFF, 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // Table-driven static patterns, one full frame each
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].digits, vecs[v].dp_in, vecs[v].blink, vecs[v].lz);
      for (int k = 0; k < 16; k++) begin
        runEdge(vecs[v].name, k, vecs[v].seg_exp, vecs[v].dp_exp);
      end
    end

    // Inputs change during digit 2. The current frame keeps showing 1111.
    // The next frame shows 2F22, with a dash on digit 2.
    applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 32; k++) begin
      if (k < 16) runEdge("tear_hold", k, {S1, S1, S1, S1}, 4'b0000);
      else        runEdge("tear_next", k, {S2, SD, S2, S2}, 4'b0000);
      if (k == 9) digits = 16'h2F22;
    end

    // Blink on digit 0: visible in frames 0-1, hidden in 2-3, visible in 4-5
    applyStimulus(16'h1234, 4'b0001, 4'b0001, 1'b0);
    for (int k = 0; k < 96; k++) begin
      logic vis;
      vis = (((k / 16) / 2) % 2) == 0;
      runEdge("blink", k, {S1, S2, S3, vis ? S4 : SOFF}, {3'b000, vis});
    end

    // Reset asserted between edges while digit 2 is lit, then the scan restarts
    applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 10; k++) runEdge("pre_reset", k, {S1, S2, S3, S4}, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_mid", 0, 4'b1111, SOFF, 1'b0);
    step();
    checkOutput("reset_held", 1, 4'b1111, SOFF, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) runEdge("post_reset", k, {S1, S2, S3, S4}, 4'b0000);

    // Enable dropped mid-frame for 10 cycles, then a clean restart
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("en_low", k, 4'b1111, SOFF, 1'b0);
    end
    en = 1'b1;
    for (int k = 0; k < 8; k++) runEdge("en_restart", k, {S1, S2, S3, S4}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg7_mux_drv.md
SEG7_MUX_DRV -- requirements
Module: seg7_mux_drv

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (range 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (≥2).
REQ-003 SHALL have parameter BLANK_CYC, default 500, anti-ghost cycles at start of each slot (0 ≤ BLANK_CYC < REFRESH_DIV).
REQ-004 SHALL have parameter BLINK_FRAMES, default 60, full scan frames per blink half-period (≥1).
REQ-005 SHALL have port clk input 1: the single system clock, all state on its rising edge.
REQ-006 SHALL have port rst_n input 1: reset, asynchronous and active-low.
REQ-007 SHALL have port en input 1: scan enable.
REQ-008 SHALL have port digits input 4*NUM_DIGITS: BCD codes, digit i at [4i+3:4i], digit 0 rightmost.
REQ-009 SHALL have port dp_in input NUM_DIGITS: decimal point request per digit.
REQ-010 SHALL have port blink_mask input NUM_DIGITS: digits to blink.
REQ-011 SHALL have port lz_en input 1: leading-zero suppression enable.
REQ-012 SHALL have port seg output 7: active-high segments, seg[6]=A … seg[0]=G, registered.
REQ-013 SHALL have port dp output 1: active-high decimal point, registered.
REQ-014 SHALL have port an output NUM_DIGITS: active-low digit anodes, registered; at most one bit low at any time.

Function
REQ-015 SHALL run a slot counter 0..REFRESH_DIV-1 and a digit index 0..NUM_DIGITS-1; the index increments when the slot counter wraps and wraps NUM_DIGITS-1→0.
REQ-016 SHALL define a frame as slots 0..NUM_DIGITS-1; at slot counter 0 of index 0, SHALL snapshot digits, dp_in, blink_mask and lz_en into internal registers; all display decoding uses only the snapshot (no mid-frame tearing).
REQ-017 SHALL drive an all-ones while slot counter < BLANK_CYC, else drive an[index]=0 and all others 1.
REQ-018 Outputs SHALL be registered: seg/dp/an at cycle t reflect counter/index/snapshot state of cycle t-1; seg and dp SHALL be 0 whenever an is all ones.
REQ-019 SHALL decode BCD 0–9 to standard patterns (0=7'b1111110, 1=7'b0110000, 8=7'b1111111); codes 10–15 SHALL display dash 7'b0000001.
REQ-020 With snapshot lz_en=1, digit i>0 SHALL be blanked (seg=0) when it and all digits above it are 0; digit 0 is never suppressed; dp of a suppressed digit still follows dp_in.
REQ-021 SHALL keep a frame counter 0..BLINK_FRAMES-1 and a blink_phase bit (1=visible); blink_phase toggles on the last cycle of the frame in which the frame counter reaches BLINK_FRAMES-1, then the counter wraps to 0.
REQ-022 When blink_phase=0, digits with snapshot blink_mask bit set SHALL output seg=0, dp=0; their anode still scans normally.
REQ-023 While en=0, SHALL hold slot counter, index and frame counter at 0, blink_phase at 1, an all ones, seg=0, dp=0; the first cycle with en=1 is slot counter 0 of index 0 (fresh snapshot).
REQ-024 en deasserted mid-frame SHALL take effect on the next clock edge (outputs blanked one cycle later per REQ-018).

Reset
REQ-025 rst_n=0 SHALL immediately force an all ones, seg=0, dp=0, counters and index 0, blink_phase 1, snapshot registers 0, independent of clk.
REQ-026 After rst_n rises, with en=1, the first rising edge SHALL process slot counter 0 of index 0 (snapshot taken on that edge).
REQ-027 Reset asserted mid-frame SHALL abandon the frame; no partial frame resumes.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2)
REQ-028 Scan order: en=1, digits=16'h1234, masks 0 -> an sequence 1111,1110×3,1111,1101×3,1111,1011×3,1111,0111×3, repeating; seg during an=1110 is 7'b0110011 ("4").
REQ-029 Leading zeros: digits=16'h0070, lz_en=1 -> digits 3 and 2 seg=0, digit 1 shows "7" (7'b1110000), digit 0 shows "0" (7'b1111110); digits=16'h0000 -> only digit 0 lit with "0".
REQ-030 Tear-free/invalid: change digits from 16'h1111 to 16'h2F22 during index 2 -> remainder of frame still shows "1"; next frame digit 2 shows dash 7'b0000001.
REQ-031 Blink: blink_mask=4'b0001, dp_in=4'b0001 -> digit 0 lit frames 0–1, seg=0/dp=0 frames 2–3, lit frames 4–5; other digits always lit.
REQ-032 Reset/enable: assert rst_n=0 mid-slot between clock edges -> an=1111, seg=0 immediately; en=0 for 10 cycles -> an=1111 throughout, restart at an=1111 then 1110.
